// File: rtl/braille_chord_capture.sv
// Braille chord front end: synchronises and debounces six dot switches, then
// accumulates a chord while any dot is held and emits it once on full release.
module braille_chord_capture #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_MAX        = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] dots_in,
  input  logic       clear_in,
  output logic [5:0] palph_out,
  output logic       load_out,
  output logic       busy,
  output logic       err_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] EMIT    = 2'd2;
  localparam logic [1:0] ABORT   = 2'd3;

  logic [5:0]    sync1;
  logic [5:0]    sync2;
  logic [5:0]    stable;
  logic [DW-1:0] db_cnt [6];
  logic [1:0]    state;
  logic [5:0]    acc;
  logic [HW-1:0] hold;
  logic          released;
  logic          timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= dots_in;
      sync2 <= sync1;
    end
  end

  // A dot only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            stable[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign released  = (stable == 6'd0);
  assign timeout   = (hold == HOLD_LAST);
  assign err_pulse = (state == COLLECT) && !clear_in && !released && timeout;
  assign load_out  = (state == EMIT);
  assign busy      = (state == COLLECT) || (state == ABORT);

  // Cancel outranks release, which outranks the hold timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      hold      <= '0;
      palph_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!released) begin
            acc   <= stable;
            hold  <= '0;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (!timeout) hold <= hold + 1'b1;
          if (clear_in) begin
            acc   <= '0;
            state <= released ? IDLE : ABORT;
          end else if (released) begin
            palph_out <= acc;
            state     <= EMIT;
          end else if (timeout) begin
            acc   <= '0;
            state <= ABORT;
          end else begin
            acc <= acc | stable;
          end
        end
        EMIT: begin
          acc   <= '0;
          state <= IDLE;
        end
        default: begin
          acc <= '0;
          if (released) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_braille_chord_capture.sv
// Directed bench for braille_chord_capture; expected chords are queued as
// stimulus is applied and checked when the DUT pulses load_out.
module tb_braille_chord_capture;

  logic       clk;
  logic       rst;
  logic [5:0] dots_in;
  logic       clear_in;
  logic [5:0] palph_out;
  logic       load_out;
  logic       busy;
  logic       err_pulse;

  int         checks;
  int         errors;
  int         loads_seen;
  int         errs_seen;
  int         base_load;
  int         base_err;
  logic [5:0] exp_chord;
  logic [5:0] exp_q [$];

  braille_chord_capture #(.DEBOUNCE_CYCLES(4), .HOLD_MAX(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .dots_in   (dots_in),
    .clear_in  (clear_in),
    .palph_out (palph_out),
    .load_out  (load_out),
    .busy      (busy),
    .err_pulse (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] dots, input int cycles);
    dots_in = dots;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  // Bounded wait for the next load pulse.
  task automatic waitLoad(input int base);
    for (int i = 0; i < 40; i++) begin
      if (loads_seen != base) break;
      @(posedge clk);
      #2;
    end
    checkOutput("load_count", loads_seen, base + 1);
  endtask

  // Load pulses pop the scoreboard; error pulses are counted.
  always @(negedge clk) begin
    if (!rst && load_out) begin
      loads_seen++;
      if (exp_q.size() == 0) begin
        checkOutput("spurious_load", {31'd0, load_out}, 32'd0);
      end else begin
        exp_chord = exp_q.pop_front();
        checkOutput("chord", {26'd0, palph_out}, {26'd0, exp_chord});
      end
    end
    if (!rst && err_pulse) errs_seen++;
  end

  initial begin
    checks = 0; errors = 0; loads_seen = 0; errs_seen = 0;
    rst = 1'b1; dots_in = '0; clear_in = 1'b0;
    applyStimulus(6'd0, 3);
    checkOutput("rst_palph", {26'd0, palph_out}, 32'd0);
    checkOutput("rst_load", {31'd0, load_out}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_err", {31'd0, err_pulse}, 32'd0);
    rst = 1'b0;
    applyStimulus(6'd0, 5);

    $display("[TB] simultaneous chord");
    base_load = loads_seen;
    exp_q.push_back(6'b000101);
    applyStimulus(6'b000101, 10);
    checkOutput("simul_busy_mid", {31'd0, busy}, 32'd1);
    applyStimulus(6'b000101, 10);
    checkOutput("simul_busy_end", {31'd0, busy}, 32'd1);
    dots_in = 6'd0;
    waitLoad(base_load);
    applyStimulus(6'd0, 5);
    checkOutput("simul_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("simul_palph_hold", {26'd0, palph_out}, 32'h05);

    $display("[TB] staggered chord");
    base_load = loads_seen;
    exp_q.push_back(6'b001001);
    applyStimulus(6'b000001, 10);
    applyStimulus(6'b001001, 10);
    applyStimulus(6'b001000, 10);
    checkOutput("stagger_no_early_load", loads_seen, base_load);
    checkOutput("stagger_busy", {31'd0, busy}, 32'd1);
    dots_in = 6'd0;
    waitLoad(base_load);
    applyStimulus(6'd0, 5);

    $display("[TB] bounce rejection");
    base_load = loads_seen;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 6; k++) begin
        applyStimulus((k < 3) ? 6'b000010 : 6'b000000, 1);
        checkOutput("bounce_busy", {31'd0, busy}, 32'd0);
      end
    end
    applyStimulus(6'd0, 10);
    checkOutput("bounce_loads", loads_seen, base_load);
    checkOutput("bounce_palph", {26'd0, palph_out}, 32'h09);

    $display("[TB] hold timeout");
    base_load = loads_seen;
    base_err = errs_seen;
    applyStimulus(6'b111111, 50);
    checkOutput("timeout_not_early", errs_seen, base_err);
    applyStimulus(6'b111111, 30);
    checkOutput("timeout_err_once", errs_seen, base_err + 1);
    checkOutput("timeout_busy", {31'd0, busy}, 32'd1);
    applyStimulus(6'b111111, 120);
    checkOutput("timeout_busy_late", {31'd0, busy}, 32'd1);
    checkOutput("timeout_err_total", errs_seen, base_err + 1);
    applyStimulus(6'd0, 10);
    checkOutput("timeout_busy_released", {31'd0, busy}, 32'd0);
    checkOutput("timeout_no_load", loads_seen, base_load);
    checkOutput("timeout_palph", {26'd0, palph_out}, 32'h09);

    $display("[TB] cancel");
    base_load = loads_seen;
    base_err = errs_seen;
    applyStimulus(6'b010000, 12);
    checkOutput("cancel_busy_before", {31'd0, busy}, 32'd1);
    clear_in = 1'b1;
    applyStimulus(6'b010000, 1);
    clear_in = 1'b0;
    checkOutput("cancel_busy_abort", {31'd0, busy}, 32'd1);
    applyStimulus(6'b010000, 5);
    applyStimulus(6'd0, 10);
    checkOutput("cancel_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("cancel_no_load", loads_seen, base_load);
    checkOutput("cancel_no_err", errs_seen, base_err);
    exp_q.push_back(6'b000001);
    applyStimulus(6'b000001, 12);
    dots_in = 6'd0;
    waitLoad(base_load);
    applyStimulus(6'd0, 5);

    $display("[TB] reset mid-chord");
    base_load = loads_seen;
    applyStimulus(6'b000011, 12);
    checkOutput("rstmid_busy_before", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstmid_palph", {26'd0, palph_out}, 32'd0);
    checkOutput("rstmid_load", {31'd0, load_out}, 32'd0);
    applyStimulus(6'd0, 3);
    rst = 1'b0;
    applyStimulus(6'd0, 100);
    checkOutput("rstmid_no_load", loads_seen, base_load);
    checkOutput("rstmid_busy_after", {31'd0, busy}, 32'd0);

    checkOutput("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/braille_chord_capture.md
Name: braille_chord_capture

Overview:
- Upstream input stage for gamemode; drives its player-letter inputs palphin/loadin.
- Takes six raw Braille dot switches, synchronises and debounces each, and accumulates a chord while any dot is held.
- On full release, presents the 6-bit chord and emits one load pulse. Partial presses and bounce never produce a letter.
- Chords held too long are rejected, with an error pulse.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised dot must disagree with its stable value before the stable value flips.
- HOLD_MAX, 4096: maximum cycles spent in COLLECT before the chord is aborted.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- dots_in  input  6  raw dot switches, bit i = Braille dot i+1, asynchronous, 1 = pressed
- clear_in  input  1  synchronous cancel of any chord in progress
- palph_out  output  6  last accepted chord; feeds gamemode palphin
- load_out  output  1  one-cycle pulse, chord accepted; feeds gamemode loadin
- busy  output  1  high while state is COLLECT or ABORT
- err_pulse  output  1  one-cycle pulse on hold timeout

Behaviour:

Reset:
- Reset is asynchronous, active-high. All flops clear.
- palph_out=0, load_out=0, busy=0, err_pulse=0.
- Stable dots=0, accumulator=0, counters=0, state=IDLE.

Input conditioning, per dot:
- Two-flop synchroniser, then debouncer.
- Debounce counter increments while the synchronised bit differs from the stable bit; it clears to 0 on any agreeing cycle.
- When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable bit flips and the counter clears.
- Press-to-stable latency = 2 + DEBOUNCE_CYCLES cycles.
- Counter width = $clog2(DEBOUNCE_CYCLES)+1.

FSM states (registered):
- IDLE:
  - If stable≠0: acc<=stable, hold counter<=0, go to COLLECT.
- COLLECT:
  - Each cycle acc<=acc|stable; hold counter increments.
  - If stable==0: go to EMIT.
  - Else if hold counter==HOLD_MAX-1: go to ABORT, err_pulse=1 for that transition cycle.
- EMIT, one cycle:
  - palph_out<=acc, load_out=1, acc<=0, go to IDLE.
- ABORT:
  - acc<=0, no load.
  - Go to IDLE when stable==0.

Outputs and timing:
- load_out is high exactly in the EMIT cycle. palph_out changes in that same cycle and holds until the next EMIT.
- Latency: from the first cycle stable==0 is observed in COLLECT, load_out asserts 1 cycle later.
- busy = (state==COLLECT)||(state==ABORT). busy is low in EMIT.
- Release order is irrelevant: the emitted chord is the OR of every dot stable-high at any point during COLLECT.

clear_in:
- In COLLECT: go to ABORT, or to IDLE if stable==0 that cycle. acc<=0, no err_pulse, no load.
- In IDLE or ABORT: no effect.
- In EMIT: the emit completes. clear_in has priority only from the next cycle.
- clear_in beats both timeout and release when simultaneous in COLLECT.

Boundary conditions:
- Release and timeout in the same COLLECT cycle: release wins (EMIT).
- acc is never 0 at EMIT, because COLLECT is entered only with stable≠0.
- Hold counter saturates; it does not wrap.
- Reset mid-chord aborts silently. No load_out follows once reset deasserts while dots remain held.
- A new press arriving in the EMIT cycle is picked up from IDLE on the next cycle.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_MAX=64):
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately; no load_out for 100 cycles with dots_in=0.
- Simultaneous chord: dots_in=6'b000101 held 20 cycles, then 0 -> exactly one load_out pulse, palph_out=6'b000101, busy high throughout the press.
- Staggered chord: dot1 high at t=0, dot4 high at t=10, dot1 low at t=20, dot4 low at t=30 -> single load_out after the final release, palph_out=6'b001001. No pulse at t≈20+latency.
- Bounce rejection: dot2 high for 3 cycles then low, repeated 5 times -> busy stays 0, no load_out, palph_out unchanged.
- Timeout: dots_in=6'b111111 held 200 cycles -> one err_pulse ~64 cycles after COLLECT entry, busy stays 1 until release+debounce, no load_out, palph_out keeps prior value.
- Cancel: mid-chord 6'b010000, pulse clear_in -> no load_out on release, busy falls after debounced release; next chord 6'b000001 emits palph_out=6'b000001 normally.
